// File: rtl/rom_scan_accumulator_pkg.sv
// Shared definitions for the ROM scan accumulator: default widths and FSM state encoding.
package rom_scan_accumulator_pkg;

   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DATA_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_READ = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/rom_scan_accumulator.sv
// Scans a window of an external combinational ROM, accumulating the sum and tracking the
// largest word and its address. The ROM itself lives beside this block, one level up.
module rom_scan_accumulator
   import rom_scan_accumulator_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] count,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W+3:0] sum,
   output logic [DATA_W-1:0] max_val,
   output logic [ADDR_W-1:0] max_addr
);

   localparam int unsigned SUM_W = DATA_W + 4;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] remain, remain_nxt;
   logic [ADDR_W-1:0] rom_addr_nxt;
   logic [SUM_W-1:0]  sum_nxt;
   logic [DATA_W-1:0] max_val_nxt;
   logic [ADDR_W-1:0] max_addr_nxt;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         remain   <= '0;
         rom_addr <= '0;
         sum      <= '0;
         max_val  <= '0;
         max_addr <= '0;
      end else begin
         state    <= state_nxt;
         remain   <= remain_nxt;
         rom_addr <= rom_addr_nxt;
         sum      <= sum_nxt;
         max_val  <= max_val_nxt;
         max_addr <= max_addr_nxt;
      end
   end

   // Next-state and datapath update; results hold in IDLE/DONE until the next accepted start
   always_comb begin
      state_nxt    = state;
      remain_nxt   = remain;
      rom_addr_nxt = rom_addr;
      sum_nxt      = sum;
      max_val_nxt  = max_val;
      max_addr_nxt = max_addr;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt    = ST_READ;
               rom_addr_nxt = start_addr;
               remain_nxt   = count;
               sum_nxt      = '0;
               max_val_nxt  = '0;
               max_addr_nxt = '0;
            end
         end
         ST_READ: begin
            sum_nxt      = sum + SUM_W'(rom_data);
            rom_addr_nxt = rom_addr + ADDR_W'(1);
            remain_nxt   = remain - ADDR_W'(1);
            if (rom_data > max_val) begin
               max_val_nxt  = rom_data;
               max_addr_nxt = rom_addr;
            end
            if (remain == '0) begin
               state_nxt  = ST_DONE;
               remain_nxt = '0;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_READ);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rom_scan_accumulator.sv
// Randomized and directed self-checking bench for rom_scan_accumulator with a
// behavioural ROM and a sum/max reference model computed from the scan window.
module tb_rom_scan_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] start_addr;
   logic [3:0] count;
   logic [3:0] rom_addr;
   logic [4:0] rom_data;
   logic       busy;
   logic       done;
   logic [8:0] sum;
   logic [4:0] max_val;
   logic [3:0] max_addr;

   int tests = 0;
   int fails = 0;

   logic       chk_en = 1'b0;
   logic       exp_busy, exp_done;
   logic [8:0] exp_sum;
   logic [4:0] exp_max;
   logic [3:0] exp_max_addr, exp_addr;
   int         busy_cycles = 0;
   int         done_pulses = 0;

   rom_scan_accumulator dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
      .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
      .sum(sum), .max_val(max_val), .max_addr(max_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] rom_word(input int a);
      return 5'((3 * a) % 32);
   endfunction

   assign rom_data = rom_word(int'(rom_addr));

   // Expected sum/max after the first k words of a scan from sa
   task automatic model(input int sa, input int k, output logic [8:0] s,
                        output logic [4:0] m, output logic [3:0] ma);
      int a;
      logic [4:0] w;
      s = '0; m = '0; ma = '0;
      for (int i = 0; i < k; i++) begin
         a = (sa + i) % 16;
         w = rom_word(a);
         s = s + 9'(w);
         if (w > m) begin
            m  = w;
            ma = 4'(a);
         end
      end
   endtask

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      if (chk_en) begin
         check("busy", int'(busy), int'(exp_busy));
         check("done", int'(done), int'(exp_done));
         check("sum", int'(sum), int'(exp_sum));
         check("max_val", int'(max_val), int'(exp_max));
         check("max_addr", int'(max_addr), int'(exp_max_addr));
         check("rom_addr", int'(rom_addr), int'(exp_addr));
      end
   end

   task automatic set_exp(input int sa, input int k, input logic b, input logic d);
      model(sa, k, exp_sum, exp_max, exp_max_addr);
      exp_addr = 4'((sa + k) % 16);
      exp_busy = b;
      exp_done = d;
   endtask

   // One scan; with noise, start is re-asserted with junk parameters every busy/done cycle
   task automatic scan(input int sa, input int cnt, input bit noise);
      @(negedge clk);
      start = 1'b1; start_addr = 4'(sa); count = 4'(cnt);
      @(posedge clk); #1;
      start = noise;
      if (noise) begin start_addr = 4'($urandom); count = 4'($urandom); end
      set_exp(sa, 0, 1'b1, 1'b0);
      chk_en = 1'b1;
      for (int k = 1; k <= cnt; k++) begin
         @(posedge clk); #1;
         set_exp(sa, k, 1'b1, 1'b0);
         if (noise) start_addr = 4'($urandom);
      end
      @(posedge clk); #1;
      set_exp(sa, cnt + 1, 1'b0, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      exp_done = 1'b0;
   endtask

   initial begin
      int pulses0;
      rst = 1'b1; start = 1'b0; start_addr = '0; count = '0;
      exp_busy = 0; exp_done = 0; exp_sum = '0; exp_max = '0; exp_max_addr = '0; exp_addr = '0;
      #2;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_sum", int'(sum), 0);
      check("reset_rom_addr", int'(rom_addr), 0);
      @(posedge clk); #1; rst = 1'b0;

      // Single word
      pulses0 = done_pulses;
      scan(2, 0, 1'b0);
      check("single_sum", int'(sum), 6);
      check("single_max", int'(max_val), 6);
      check("single_max_addr", int'(max_addr), 2);
      check("single_done_pulses", done_pulses - pulses0, 1);

      // Short scan, busy exactly 3 cycles
      busy_cycles = 0;
      scan(0, 2, 1'b0);
      check("short_sum", int'(sum), 9);
      check("short_max", int'(max_val), 6);
      check("short_max_addr", int'(max_addr), 2);
      check("short_busy_cycles", busy_cycles, 3);

      // Wrap-around
      scan(14, 3, 1'b0);
      check("wrap_sum", int'(sum), 26);
      check("wrap_max", int'(max_val), 13);
      check("wrap_max_addr", int'(max_addr), 15);

      // Full scan
      scan(0, 15, 1'b0);
      check("full_sum", int'(sum), 200);
      check("full_max", int'(max_val), 30);
      check("full_max_addr", int'(max_addr), 10);

      // Start while busy is ignored
      pulses0 = done_pulses;
      scan(0, 2, 1'b1);
      check("busy_start_sum", int'(sum), 9);
      check("busy_start_max_addr", int'(max_addr), 2);
      check("busy_start_done_pulses", done_pulses - pulses0, 1);

      // All-zero window: address 0 only
      scan(0, 0, 1'b0);
      check("zero_max", int'(max_val), 0);
      check("zero_max_addr", int'(max_addr), 0);

      // Reset in the second READ cycle of a full scan
      pulses0 = done_pulses;
      @(negedge clk);
      start = 1'b1; start_addr = 4'd0; count = 4'd15;
      @(posedge clk); #1; start = 1'b0; set_exp(0, 0, 1'b1, 1'b0); chk_en = 1'b1;
      @(posedge clk); #1; set_exp(0, 1, 1'b1, 1'b0);
      #2; rst = 1'b1;
      exp_busy = 0; exp_done = 0; exp_sum = '0; exp_max = '0; exp_max_addr = '0; exp_addr = '0;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_sum", int'(sum), 0);
      check("rst_max_val", int'(max_val), 0);
      check("rst_max_addr", int'(max_addr), 0);
      check("rst_rom_addr", int'(rom_addr), 0);
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      scan(2, 0, 1'b0);
      check("after_rst_sum", int'(sum), 6);
      check("after_rst_done_pulses", done_pulses - pulses0, 1);

      // Randomized scans, some with start noise
      for (int n = 0; n < 30; n++) begin
         int sa, cnt;
         logic [8:0] s;
         logic [4:0] m;
         logic [3:0] ma;
         sa  = int'($urandom_range(0, 15));
         cnt = int'($urandom_range(0, 15));
         pulses0 = done_pulses;
         scan(sa, cnt, 1'($urandom_range(0, 1)));
         model(sa, cnt + 1, s, m, ma);
         check("rand_final_sum", int'(sum), int'(s));
         check("rand_done_pulses", done_pulses - pulses0, 1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rom_scan_accumulator.md
ROM_SCAN_ACCUMULATOR -- requirements
Module: rom_scan_accumulator

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 5, ROM word width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, scan request, sampled only in IDLE.
REQ-006 SHALL have port start_addr, input, ADDR_W, first address to read.
REQ-007 SHALL have port count, input, ADDR_W, number of words to read minus one (0 to 15, giving 1 to 16 words).
REQ-008 SHALL have port rom_addr, output, ADDR_W, address driven to the combinational ROM (lab4ROM).
REQ-009 SHALL have port rom_data, input, DATA_W, ROM word for the current rom_addr, valid in the same cycle.
REQ-010 SHALL have port busy, output, 1, high while the scan is in READ.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port sum, output, DATA_W+4 (9), running and final sum of the words read.
REQ-013 SHALL have port max_val, output, DATA_W, largest word read.
REQ-014 SHALL have port max_addr, output, ADDR_W, address of max_val.

Function
REQ-015 SHALL implement a state machine with states IDLE, READ and DONE.
REQ-016 In IDLE, SHALL go to READ on the edge that samples start=1, and on that edge SHALL:
- load rom_addr with start_addr;
- load the remaining-word counter with count;
- clear sum, max_val and max_addr.
REQ-017 On each edge in READ, SHALL:
- add rom_data to sum;
- if rom_data > max_val (strictly greater), load max_val with rom_data and max_addr with rom_addr;
- increment rom_addr modulo 2^ADDR_W, so 15 wraps to 0;
- decrement the remaining-word counter.
REQ-018 SHALL leave READ for DONE on the edge on which the remaining-word counter is 0, after that edge has accumulated the last word.
REQ-019 SHALL hold done=1 for exactly the DONE cycle and SHALL return to IDLE on the next edge.
REQ-020 SHALL therefore assert done after edge count+1 following the start-sampling edge.
REQ-021 SHALL hold sum, max_val and max_addr stable from DONE until the next accepted start.
REQ-022 SHALL ignore start while in READ or DONE.
REQ-023 SHALL not overflow sum: width 9 bits, worst case 16 x 31 = 496.
REQ-024 When all words read are 0, SHALL report max_val=0 and max_addr=0.
REQ-025 SHALL drive busy combinationally as (state==READ) and done as (state==DONE).

Reset
REQ-026 While rst=1, SHALL force, without waiting for a clock edge:
- state to IDLE;
- rom_addr, sum, max_val, max_addr and the counter to 0;
- busy and done to 0.
REQ-027 When rst is asserted mid-scan, SHALL abandon the scan with no done pulse and SHALL accept a new start on the first edge after rst is released.

Structure
REQ-028 SHALL take the state encodings (IDLE=2'b00, READ=2'b01, DONE=2'b10) and the ADDR_W/DATA_W defaults from the shared lab4 package/include file.
REQ-029 SHALL contain no sub-modules; the ROM SHALL be instantiated beside this block at the next level up, not inside it.

Verification
REQ-030 The bench SHALL use a behavioural ROM with data[a] = (3*a) mod 32. This gives addr0=00000 and addr2=00110, matching the lab4ROM checks.
REQ-031 Single word: start_addr=2, count=0 -> done after 1 edge; sum=6, max_val=6, max_addr=2.
REQ-032 Short scan: start_addr=0, count=2 -> words 0,3,6; done after 3 edges; sum=9, max_val=6, max_addr=2; busy high for exactly 3 cycles.
REQ-033 Wrap-around: start_addr=14, count=3 -> addresses 14,15,0,1 and words 10,13,0,3; sum=26, max_val=13, max_addr=15.
REQ-034 Full scan: start_addr=0, count=15 -> done after 16 edges; sum=200, max_val=30, max_addr=10.
REQ-035 Start while busy: pulse start with start_addr=5 during the REQ-032 scan -> REQ-032 results unchanged, exactly one done pulse.
REQ-036 Reset mid-scan: assert rst in the 2nd READ cycle of the REQ-034 scan -> all outputs 0 immediately and no done. A subsequent start_addr=2, count=0 -> sum=6.
